// File: rtl/la_fork4.sv
// One-to-four lazy fork: captures one upstream payload and holds it until every
// destination selected by its mask has taken it, then accepts the next one.
module la_fork4 #(
   parameter              PROP = "DEFAULT",
   parameter int unsigned DW   = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [3:0]    in_mask,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [DW-1:0] out_data,
   output logic          busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [3:0]    pending_q;
   logic [3:0]    pending_nxt;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_nxt;
   logic [3:0]    remain_c;
   logic [0:0]    state_c;
   logic          up_xfer_c;
   logic          unused_prop;

   // PROP only selects an implementation variant elsewhere; reduced here so it is referenced
   assign unused_prop = ^PROP;

   // State is implied by the pending set rather than kept in a separate register
   always_comb begin
      remain_c    = 4'b0000;
      state_c     = ST_IDLE;
      in_ready    = 1'b0;
      up_xfer_c   = 1'b0;
      pending_nxt = pending_q;
      data_nxt    = data_q;

      remain_c = pending_q & ~out_ready;
      state_c  = (pending_q != 4'b0000) ? ST_BUSY : ST_IDLE;

      // Accept when nothing would still be owed after this cycle's handshakes
      case (state_c)
         ST_IDLE: in_ready = 1'b1;
         ST_BUSY: in_ready = (remain_c == 4'b0000);
         default: in_ready = 1'b0;
      endcase

      up_xfer_c = in_valid & in_ready;

      if (up_xfer_c) begin
         pending_nxt = in_mask;
         data_nxt    = in_data;
      end else begin
         pending_nxt = remain_c;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pending_q <= 4'b0000;
         data_q    <= '0;
      end else begin
         pending_q <= pending_nxt;
         data_q    <= data_nxt;
      end
   end

   assign out_valid = pending_q;
   assign out_data  = data_q;
   assign busy      = |pending_q;

endmodule

// File: tb/tb_la_fork4.sv
// Self-checking bench for la_fork4: directed scenarios plus a long random run
// against a per-destination "owed payload" reference model.
module tb_la_fork4;

   localparam int unsigned DW = 8;

   logic          clk;
   logic          nreset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [3:0]    in_mask;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [DW-1:0] out_data;
   logic          busy;

   int checks;
   int errors;

   // Reference model: which destinations are still owed the current payload
   logic [DW-1:0] m_data;
   bit            m_owed [4];
   int            m_sent [4];
   int            m_recv [4];

   la_fork4 #(.PROP("DEFAULT"), .DW(DW)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      v = 4'b0000;
      for (int i = 0; i < 4; i++) v[i] = m_owed[i];
      return v;
   endfunction

   // A new payload may enter only if every owed destination takes its copy now
   function automatic logic m_ready();
      logic r;
      r = 1'b1;
      for (int i = 0; i < 4; i++)
         if (m_owed[i] && !out_ready[i]) r = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      m_data = '0;
      for (int i = 0; i < 4; i++) begin
         m_owed[i] = 1'b0;
         m_sent[i] = 0;
         m_recv[i] = 0;
      end
   endtask

   task automatic drive(input logic iv, input logic [3:0] m, input logic [3:0] ordy,
                        input logic [DW-1:0] d);
      in_valid  = iv;
      in_mask   = m;
      out_ready = ordy;
      in_data   = d;
      #1;
   endtask

   // Apply the current inputs to the model, then move to the next clock cycle
   task automatic advance();
      logic acc;
      acc = in_valid && m_ready();
      for (int i = 0; i < 4; i++)
         if (m_owed[i] && out_ready[i]) begin
            m_owed[i] = 1'b0;
            m_recv[i]++;
         end
      if (acc) begin
         m_data = in_data;
         for (int i = 0; i < 4; i++) begin
            m_owed[i] = in_mask[i];
            if (in_mask[i]) m_sent[i]++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 8'h00);
      model_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: out_valid=%h busy=%b in_ready=%b out_data=%h, want 0 0 1 00",
                  out_valid, busy, in_ready, out_data);
      end
      nreset = 1'b1;
      // First edge after release must already accept a transfer
      drive(1'b1, 4'hF, 4'h0, 8'h3C);
      advance();
      drive(1'b0, 4'h0, 4'h0, 8'h00);
      checks++;
      if (out_valid !== 4'hF || out_data !== 8'h3C) begin
         errors++;
         $display("FAIL first_after_reset: out_valid=%h out_data=%h, want f 3c", out_valid, out_data);
      end
      drive(1'b0, 4'h0, 4'hF, 8'h00);
      advance();
   endtask

   task automatic test_reset_mid_busy();
      drive(1'b1, 4'b1010, 4'h0, 8'h96);
      advance();
      drive(1'b0, 4'h0, 4'h0, 8'h00);
      checks++;
      if (out_valid !== 4'b1010 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_busy_setup: out_valid=%h busy=%b in_ready=%b, want a 1 0",
                  out_valid, busy, in_ready);
      end
      nreset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 4'h0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: out_valid=%h busy=%b in_ready=%b out_data=%h, want 0 0 1 00",
                  out_valid, busy, in_ready, out_data);
      end
      model_reset();
      @(negedge clk);
      nreset = 1'b1;
      drive(1'b0, 4'h0, 4'hF, 8'h00);
      advance();
      checks++;
      if (out_valid !== 4'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL no_replay: out_valid=%h busy=%b, want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_broadcast();
      drive(1'b1, 4'hF, 4'hF, 8'hA5);
      advance();
      checks++;
      if (out_valid !== 4'hF || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL broadcast: out_valid=%h out_data=%h, want f a5", out_valid, out_data);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, 4'hF, 4'hF, 8'(k));
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", k, in_ready);
         end
         advance();
         checks++;
         if (out_valid !== 4'hF || out_data !== 8'(k)) begin
            errors++;
            $display("FAIL stream_out[%0d]: out_valid=%h out_data=%h, want f %h",
                     k, out_valid, out_data, 8'(k));
         end
      end
      drive(1'b0, 4'h0, 4'hF, 8'h00);
      advance();
   endtask

   task automatic test_staggered();
      logic [3:0] ordy_seq [4];
      logic [3:0] pend_seq [4];
      logic       rdy_seq  [4];
      ordy_seq = '{4'h1, 4'h4, 4'h2, 4'h8};
      pend_seq = '{4'hE, 4'hA, 4'h8, 4'h0};
      rdy_seq  = '{1'b0, 1'b0, 1'b0, 1'b1};
      drive(1'b1, 4'hF, 4'h0, 8'h5C);
      advance();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 4'h0, ordy_seq[k], 8'h00);
         checks++;
         if (in_ready !== rdy_seq[k]) begin
            errors++;
            $display("FAIL stagger_ready[%0d]: in_ready=%b, want %b", k, in_ready, rdy_seq[k]);
         end
         advance();
         checks++;
         if (out_valid !== pend_seq[k]) begin
            errors++;
            $display("FAIL stagger_pending[%0d]: out_valid=%h, want %h", k, out_valid, pend_seq[k]);
         end
      end
   endtask

   task automatic test_partial_mask();
      drive(1'b1, 4'b0101, 4'hF, 8'h5A);
      advance();
      drive(1'b0, 4'h0, 4'hF, 8'h00);
      checks++;
      if (out_valid !== 4'b0101 || out_data !== 8'h5A) begin
         errors++;
         $display("FAIL partial_mask: out_valid=%h out_data=%h, want 5 5a", out_valid, out_data);
      end
      advance();
      checks++;
      if (out_valid !== 4'h0) begin
         errors++;
         $display("FAIL partial_clear: out_valid=%h, want 0", out_valid);
      end
   endtask

   task automatic test_zero_mask();
      logic [DW-1:0] d;
      for (int k = 0; k < 4; k++) begin
         d = DW'($urandom);
         drive(1'b1, 4'h0, 4'(k), d);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_ready[%0d]: in_ready=%b, want 1", k, in_ready);
         end
         advance();
         checks++;
         if (out_valid !== 4'h0 || busy !== 1'b0 || out_data !== d) begin
            errors++;
            $display("FAIL zero_mask_out[%0d]: out_valid=%h busy=%b out_data=%h, want 0 0 %h",
                     k, out_valid, busy, out_data, d);
         end
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int c = 0; c < 10000; c++) begin
         drive(($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom), DW'($urandom));
         checks++;
         if (in_ready !== m_ready() || out_valid !== m_valid() || busy !== (m_valid() != 4'h0)
             || ((m_valid() != 4'h0) && out_data !== m_data)) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d]: in_ready=%b out_valid=%h busy=%b out_data=%h, want %b %h %b %h",
                        c, in_ready, out_valid, busy, out_data, m_ready(), m_valid(),
                        (m_valid() != 4'h0), m_data);
         end
         advance();
      end
      drive(1'b0, 4'h0, 4'hF, 8'h00);
      advance();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (m_recv[i] !== m_sent[i] || m_recv[i] == 0) begin
            errors++;
            $display("FAIL random_count[%0d]: delivered=%0d, want %0d (nonzero)", i, m_recv[i], m_sent[i]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      nreset = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 8'h00);
      test_reset();
      test_reset_mid_busy();
      test_broadcast();
      test_back_to_back();
      test_staggered();
      test_partial_mask();
      test_zero_mask();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/la_fork4.md
LA_FORK4 -- requirements
Module: la_fork4

Interface
REQ-001 Parameter PROP, default "DEFAULT"; implementation-selection string, no functional effect in RTL.
REQ-002 Parameter DW, default 8; payload width in bits, legal range 1..1024.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 nreset  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream transfer request.
REQ-006 in_ready  output  1  block can accept upstream transfer this cycle.
REQ-007 in_data  input  DW  upstream payload.
REQ-008 in_mask  input  4  destination select for the offered transfer; bit i enables output i.
REQ-009 out_valid  output  4  per-destination valid, bit i for output i.
REQ-010 out_ready  input  4  per-destination ready, bit i for output i.
REQ-011 out_data  output  DW  registered payload, common to all four destinations.
REQ-012 busy  output  1  high while a captured transfer has undelivered destinations.

Function
REQ-013 Upstream transfer occurs on a cycle with in_valid & in_ready; downstream transfer i occurs on a cycle with out_valid[i] & out_ready[i].
REQ-014 Two states: IDLE (pending==0) and BUSY (pending!=0); pending is a 4-bit register.
REQ-015 out_valid SHALL equal pending; out_data SHALL equal the data register; busy SHALL equal |pending.
REQ-016 in_ready SHALL be 1 in IDLE; in BUSY it SHALL be 1 only when (pending & ~out_ready)==0, i.e. every remaining destination completes this cycle.
REQ-017 On an upstream transfer, data register loads in_data and pending loads in_mask in the same edge; latency from upstream transfer to out_valid is one cycle.
REQ-018 Without an upstream transfer, pending SHALL clear each bit i for which downstream transfer i occurs; other bits hold.
REQ-019 Upstream transfer and final downstream transfer in the same cycle SHALL sustain one transfer per cycle with no bubble; new pending = in_mask.
REQ-020 in_mask==0 on an upstream transfer SHALL be accepted and discarded; pending stays 0 and no out_valid asserts.
REQ-021 Data register SHALL not change except on an upstream transfer; out_data is stable while any out_valid bit is high.
REQ-022 Each destination SHALL receive each captured payload exactly once; order of destination completion is unconstrained.
REQ-023 out_valid[i] SHALL not deassert until downstream transfer i occurs (no withdrawal).
REQ-024 out_ready values on non-pending destinations SHALL have no effect.
REQ-025 in_ready SHALL not depend combinationally on in_valid, in_data or in_mask.

Reset
REQ-026 nreset low SHALL asynchronously force pending=0, giving out_valid=0, busy=0, in_ready=1.
REQ-027 Data register SHALL be reset to all zeros.
REQ-028 Reset asserted mid-transfer SHALL abandon undelivered destinations; no payload is replayed after release.
REQ-029 First upstream transfer is possible on the first rising edge after nreset deasserts.

Structure
REQ-030 No shared package; the only constants are the parameters DW and PROP, and the block SHALL be self-contained in one module.
REQ-031 No sub-module; pending register, data register and ready logic SHALL be flat inside la_fork4.
REQ-032 Combinational in_ready path is the only out_ready-to-input path; out_valid and out_data SHALL be register outputs.

Verification
REQ-033 Reset: nreset=0 mid-BUSY with pending=4'b1010 -> out_valid=0, busy=0, in_ready=1, out_data=0 immediately, before the next clock edge.
REQ-034 Broadcast: in_data=8'hA5, in_mask=4'hF, out_ready=4'hF always -> out_valid=4'hF, out_data=8'hA5 one cycle later; back-to-back inputs 8'h01..8'h10 stream at one per cycle.
REQ-035 Staggered accept: mask=4'hF, out_ready 4'h1, 4'h4, 4'h2, 4'h8 on successive cycles -> pending 4'hE, 4'hA, 4'h8, 4'h0; in_ready=1 only in the last of those cycles.
REQ-036 Partial mask: in_mask=4'b0101, out_ready=4'hF -> only out_valid[0] and out_valid[2] assert, for one cycle.
REQ-037 Zero mask: in_mask=0, in_valid=1 -> accepted with in_ready=1 every cycle; out_valid stays 0; out_data updates to in_data.
REQ-038 Random: random in_valid, in_mask and out_ready over 10k cycles with a scoreboard -> each payload reaches exactly its masked destinations once, with no withdrawal and out_data stable while valid.
